memory_stage: RTL and testbench
===============================

# memory_stage

MIPS memory-access stage with a word-addressed data RAM, a multi-cycle access handshake and the MEM/WB pipeline register. It sits between EX/MEM and the WriteBack mux, and produces the registered `readData`, `ALUresult` and `MemToReg` the mux consumes. Loads and stores stall the upstream pipeline for a fixed, parameterised latency. Non-memory instructions pass through in one cycle.

## Interface
- `DEPTH_WORDS`, 256: data RAM depth in 32-bit words (power of two); `AW = log2(DEPTH_WORDS)`.
- `MEM_LATENCY`, 3: cycles per load/store access, legal range 1..15.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request.
- `MemToRegIn` input 1: WB select from EX/MEM.
- `RegWriteIn` input 1: register-write enable from EX/MEM.
- `writeRegIn` input 5: destination register.
- `ALUresultIn` input 32: ALU result; also the byte address for loads and stores.
- `storeData` input 32: store data (rt value).
- `flush` input 1: kill the current instruction.
- `stall` output 1: combinational; upstream holds all inputs stable while high.
- `MemToReg` output 1: registered MEM/WB signal.
- `RegWrite` output 1: registered MEM/WB signal.
- `writeReg` output 5: registered MEM/WB signal.
- `readData` output 32: registered MEM/WB signal.
- `ALUresult` output 32: registered MEM/WB signal.

## Operation
- Word address is `ALUresultIn[AW+1:2]`.
  - Bits [1:0] are ignored; no misalignment trap.
  - Upper bits are ignored, so the address wraps modulo `DEPTH_WORDS`.
- `memOp = MemRead | MemWrite`. If both are set, the access is a store, and the registered `readData` is 0.
- FSM states:
  - IDLE: no access in progress.
  - ACCESS: counter `cnt` (4 bits) tracks elapsed access cycles.
- Transitions:
  - IDLE, memOp & !flush, `MEM_LATENCY > 1`: go to ACCESS with `cnt = 1`.
  - IDLE, memOp & !flush, `MEM_LATENCY == 1`: access completes this cycle and the state stays IDLE.
  - ACCESS, `cnt < MEM_LATENCY-1`: increment `cnt`.
  - ACCESS, `cnt == MEM_LATENCY-1`: access completes this cycle; go to IDLE at the edge.
  - Any state, flush: go to IDLE, `cnt = 0`, and the access is aborted.
- `done = memOp & !flush & ((IDLE & MEM_LATENCY==1) | (ACCESS & cnt==MEM_LATENCY-1))`.
- `stall = memOp & !flush & !done`.
- Store: the RAM word is written only on the `done` edge; an aborted store never writes.
- Load: RAM read data is captured into `readData` on the `done` edge.
- MEM/WB register update, every edge:
  - flush, or stall high: load a bubble. `RegWrite=0`, `MemToReg=0`, `writeReg=0`, `readData=0`, `ALUresult=0`.
  - Otherwise: capture `RegWriteIn`, `MemToRegIn`, `writeRegIn` and `ALUresultIn`. `readData` is the loaded word for a load, else 0.
- RAM contents are not reset. A read of a never-written word is undefined, and the bench must not check it.

## Timing
- Reset (`rst` low, asynchronous): state IDLE, `cnt=0`, all MEM/WB outputs 0. `stall` then follows its combinational equation.
- Non-memory instruction: outputs are valid one cycle after it is presented, with no stall.
- Load or store presented in cycle 0:
  - `stall` is high in cycles 0..`MEM_LATENCY-2` and low in cycle `MEM_LATENCY-1`.
  - The MEM/WB outputs carry the instruction after the edge that ends cycle `MEM_LATENCY-1`.
  - Bubbles are emitted for the preceding `MEM_LATENCY-1` edges.
- Back-to-back memory ops: the next op starts in the cycle after `done` and is re-evaluated from IDLE. There is no dead cycle.
- `rst` asserted mid-access: the access is aborted immediately, no RAM write occurs, and outputs clear without waiting for a clock edge.
- `flush` in the same cycle as `done`: flush wins; no write occurs and a bubble is emitted.
- Store followed by a load to the same word: the load returns the newly stored value. The store commits before the load can complete.

## Test plan
- ALU op with `ALUresultIn=23`, `RegWriteIn=1`, `MemToRegIn=0`, `writeRegIn=5` -> after 1 edge: `ALUresult=23`, `RegWrite=1`, `writeReg=5`, `readData=0`, `stall=0` throughout.
- Store `storeData=8` at address 0x10, then load from 0x10 with `MemToRegIn=1`, `MEM_LATENCY=3` ->
  - each op: `stall` high for exactly 2 cycles, and 2 bubbles are emitted;
  - load: `readData=8`, `MemToReg=1`.
- Load from 0x10 + 4×`DEPTH_WORDS` (0x410 at default depth) after the previous store -> `readData=8` (address wrap).
- Store of 0xDEAD at address 0x20 with `flush` pulsed in the second stall cycle -> state returns to IDLE and a bubble is emitted; a later load from 0x20 returns the prior value (pre-write 0x1 first).
- `rst` low during the first cycle of a store of 0x55 at 0x30 -> all outputs 0 immediately and `stall` drops; a later load from 0x30 returns the pre-written 0x2.
- `MEM_LATENCY=1` build: a load from a written address completes with `stall=0`, and the data appears after 1 edge.

Source files
------------

// File: rtl/memory_stage_if.sv
// EX/MEM-side request and MEM/WB-side result bundle for memory_stage.
// master = upstream pipeline driving requests; slave = the memory stage itself.
interface memory_stage_if;
  logic        MemRead;
  logic        MemWrite;
  logic        MemToRegIn;
  logic        RegWriteIn;
  logic [4:0]  writeRegIn;
  logic [31:0] ALUresultIn;
  logic [31:0] storeData;
  logic        flush;
  logic        stall;
  logic        MemToReg;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [31:0] readData;
  logic [31:0] ALUresult;

  modport master (
    output MemRead, MemWrite, MemToRegIn, RegWriteIn, writeRegIn,
           ALUresultIn, storeData, flush,
    input  stall, MemToReg, RegWrite, writeReg, readData, ALUresult
  );

  modport slave (
    input  MemRead, MemWrite, MemToRegIn, RegWriteIn, writeRegIn,
           ALUresultIn, storeData, flush,
    output stall, MemToReg, RegWrite, writeReg, readData, ALUresult
  );
endinterface

// File: rtl/memory_stage.sv
// MIPS MEM stage: word-addressed data RAM with fixed multi-cycle access, stall
// generation and the MEM/WB register; non-memory ops pass through in one cycle.
module memory_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LATENCY = 3
) (
  input  logic           clk,
  input  logic           rst,
  memory_stage_if.slave  bus
);
  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] ram [DEPTH_WORDS];

  logic [AW-1:0] addr;
  logic          mem_op;
  logic          go;
  logic          done;
  logic          stall_int;
  logic          is_load;

  assign addr      = bus.ALUresultIn[AW+1:2];
  assign mem_op    = bus.MemRead | bus.MemWrite;
  assign go        = mem_op & ~bus.flush;
  assign is_load   = bus.MemRead & ~bus.MemWrite;
  assign stall_int = go & ~done;
  // Reset drops the visible stall immediately even if upstream still holds a request.
  assign bus.stall = stall_int & rst;

  always_comb begin
    done = 1'b0;
    if (go) begin
      if (state == IDLE) done = (MEM_LATENCY == 1);
      else               done = (cnt == LAST);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (go && !done) begin
            state_nxt = ACCESS;
            cnt_nxt   = 4'd1;
          end
        end
        ACCESS: begin
          if (!mem_op || done) begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A store commits only on its completing edge, so an aborted store never writes.
  always_ff @(posedge clk) begin
    if (done && bus.MemWrite) ram[addr] <= bus.storeData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.RegWrite  <= 1'b0;
      bus.MemToReg  <= 1'b0;
      bus.writeReg  <= 5'd0;
      bus.readData  <= 32'd0;
      bus.ALUresult <= 32'd0;
    end else if (bus.flush || stall_int) begin
      bus.RegWrite  <= 1'b0;
      bus.MemToReg  <= 1'b0;
      bus.writeReg  <= 5'd0;
      bus.readData  <= 32'd0;
      bus.ALUresult <= 32'd0;
    end else begin
      bus.RegWrite  <= bus.RegWriteIn;
      bus.MemToReg  <= bus.MemToRegIn;
      bus.writeReg  <= bus.writeRegIn;
      bus.readData  <= (done && is_load) ? ram[addr] : 32'd0;
      bus.ALUresult <= bus.ALUresultIn;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus a randomized op stream checked
// against a word-array model with per-op latency/bubble expectations.
module tb_memory_stage;
  localparam int LAT   = 3;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  memory_stage_if bus  ();
  memory_stage_if bus1 ();

  memory_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(LAT)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  memory_stage #(.DEPTH_WORDS(DEPTH), .MEM_LATENCY(1)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] model [int];

  task automatic drive(input bit rd, input bit wr, input bit m2r, input bit rw,
                       input logic [4:0] wreg, input logic [31:0] alu,
                       input logic [31:0] sdat, input bit fl);
    bus.MemRead     = rd;
    bus.MemWrite    = wr;
    bus.MemToRegIn  = m2r;
    bus.RegWriteIn  = rw;
    bus.writeRegIn  = wreg;
    bus.ALUresultIn = alu;
    bus.storeData   = sdat;
    bus.flush       = fl;
  endtask

  task automatic idle();
    @(negedge clk);
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
  endtask

  // One instruction: expected stall for each of its cycles and expected MEM/WB
  // value after each edge, derived from the op kind and LAT alone.
  task automatic run_op(input bit rd, input bit wr, input bit m2r, input bit rw,
                        input logic [4:0] wreg, input logic [31:0] alu,
                        input logic [31:0] sdat, input int flush_at,
                        input string tag);
    int n;
    int key;
    bit memop;
    bit fl;
    bit exp_stall;
    logic [31:0] exp_rd;
    logic [70:0] exp_o;
    logic [70:0] got_o;
    memop = rd | wr;
    n     = memop ? LAT : 1;
    key   = int'(alu[9:2]);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      fl = (c == flush_at);
      drive(rd, wr, m2r, rw, wreg, alu, sdat, fl);
      #1;
      exp_stall = memop && !fl && (c < n - 1);
      total++;
      if (bus.stall !== exp_stall) begin
        bad++;
        $display("FAIL %s stall cyc%0d: got %b want %b", tag, c, bus.stall, exp_stall);
      end
      @(posedge clk);
      #1;
      if (fl || c < n - 1) begin
        exp_o = '0;
      end else begin
        exp_rd = (rd && !wr) ? model[key] : 32'd0;
        exp_o  = {rw, m2r, wreg, exp_rd, alu};
        if (wr) model[key] = sdat;
      end
      got_o = {bus.RegWrite, bus.MemToReg, bus.writeReg, bus.readData, bus.ALUresult};
      total++;
      if (got_o !== exp_o) begin
        bad++;
        $display("FAIL %s memwb edge%0d: got %h want %h", tag, c, got_o, exp_o);
      end
      if (fl) break;
    end
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    bus1.MemRead = 0; bus1.MemWrite = 0; bus1.MemToRegIn = 0; bus1.RegWriteIn = 0;
    bus1.writeRegIn = 0; bus1.ALUresultIn = 0; bus1.storeData = 0; bus1.flush = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.RegWrite, bus.MemToReg, bus.writeReg, bus.readData, bus.ALUresult} !== 71'd0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0",
               {bus.RegWrite, bus.MemToReg, bus.writeReg, bus.readData, bus.ALUresult});
    end
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL reset stall: got %b want 0", bus.stall);
    end
    rst = 1'b1;
  endtask

  task automatic test_alu();
    run_op(0, 0, 0, 1, 5'd5, 32'd23, 32'd0, -1, "alu");
  endtask

  task automatic test_store_load();
    run_op(0, 1, 0, 0, 5'd0, 32'h10, 32'd8, -1, "store10");
    run_op(1, 0, 1, 1, 5'd7, 32'h10, 32'd0, -1, "load10");
  endtask

  task automatic test_wrap();
    run_op(1, 0, 1, 1, 5'd9, 32'h10 + 4 * DEPTH, 32'd0, -1, "load_wrap");
  endtask

  task automatic test_flush();
    run_op(0, 1, 0, 0, 5'd0, 32'h20, 32'h1, -1, "prewrite20");
    run_op(0, 1, 0, 0, 5'd0, 32'h20, 32'hDEAD, 1, "flush_store20");
    run_op(1, 0, 1, 1, 5'd3, 32'h20, 32'd0, -1, "load20");
    run_op(0, 1, 0, 0, 5'd0, 32'h24, 32'hBEEF, LAT - 1, "flush_on_done");
    run_op(0, 0, 0, 1, 5'd4, 32'h77, 32'd0, -1, "alu_after_flush");
  endtask

  task automatic test_reset_mid();
    run_op(0, 1, 0, 0, 5'd0, 32'h30, 32'h2, -1, "prewrite30");
    run_op(0, 0, 0, 1, 5'd11, 32'h1234, 32'd0, -1, "alu_pre_rst");
    @(negedge clk);
    drive(0, 1, 0, 0, 5'd0, 32'h30, 32'h55, 0);
    #1;
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid stall_before: got %b want 1", bus.stall);
    end
    #1 rst = 1'b0;
    #1;
    total++;
    if ({bus.RegWrite, bus.MemToReg, bus.writeReg, bus.readData, bus.ALUresult} !== 71'd0) begin
      bad++;
      $display("FAIL rst_mid outputs: got %h want 0",
               {bus.RegWrite, bus.MemToReg, bus.writeReg, bus.readData, bus.ALUresult});
    end
    total++;
    if (bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid stall: got %b want 0", bus.stall);
    end
    @(negedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 5'd0, 32'd0, 32'd0, 0);
    rst = 1'b1;
    run_op(1, 0, 1, 1, 5'd12, 32'h30, 32'd0, -1, "load30");
  endtask

  task automatic test_latency_one();
    @(negedge clk);
    bus1.MemWrite = 1; bus1.MemRead = 0; bus1.ALUresultIn = 32'h40; bus1.storeData = 32'h77;
    bus1.RegWriteIn = 0; bus1.MemToRegIn = 0; bus1.writeRegIn = 0;
    #1;
    total++;
    if (bus1.stall !== 1'b0) begin
      bad++;
      $display("FAIL lat1 store stall: got %b want 0", bus1.stall);
    end
    @(negedge clk);
    bus1.MemWrite = 0; bus1.MemRead = 1; bus1.MemToRegIn = 1; bus1.RegWriteIn = 1;
    bus1.writeRegIn = 5'd2;
    #1;
    total++;
    if (bus1.stall !== 1'b0) begin
      bad++;
      $display("FAIL lat1 load stall: got %b want 0", bus1.stall);
    end
    @(posedge clk);
    #1;
    total++;
    if ({bus1.MemToReg, bus1.RegWrite, bus1.writeReg, bus1.readData} !== {1'b1, 1'b1, 5'd2, 32'h77}) begin
      bad++;
      $display("FAIL lat1 load data: got %h want %h",
               {bus1.MemToReg, bus1.RegWrite, bus1.writeReg, bus1.readData},
               {1'b1, 1'b1, 5'd2, 32'h77});
    end
    @(negedge clk);
    bus1.MemRead = 0; bus1.MemToRegIn = 0; bus1.RegWriteIn = 0; bus1.writeRegIn = 0;
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 60; i++) begin
      int kind;
      int fat;
      logic [31:0] alu;
      bit rd, wr;
      kind = $urandom_range(0, 3);
      alu  = $urandom;
      alu[9:2] = 8'(64 + $urandom_range(0, 7));
      rd = (kind == 1) || (kind == 3);
      wr = (kind == 2) || (kind == 3);
      if (kind == 1 && !model.exists(int'(alu[9:2]))) begin
        rd = 0;
        wr = 1;
      end
      fat = ($urandom_range(0, 5) == 0) ? $urandom_range(0, LAT - 1) : -1;
      run_op(rd, wr, 1'($urandom), 1'($urandom), 5'($urandom), alu, $urandom, fat, "rand");
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_wrap();
    test_flush();
    test_reset_mid();
    idle();
    test_latency_one();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
